instr_encoder_loader: RTL and testbench
=======================================

Name: instr_encoder_loader

Overview:
- Inverse of the processor's instruction decoder.
- Accepts one symbolic instruction command per valid/ready handshake and packs it into the 27-bit instruction word.
- Writes the words sequentially into instruction memory from address 0 until EndProg is written or memory is full.
- Sits between the host/boot command source and the instruction RAM write port; runs before the processor leaves reset.

Parameters:
- ADDR_W, 7, instruction memory address width.
- DEPTH, 128, number of writable words; must be <= 2**ADDR_W.

Ports:
- system1000  input  1  clock; all state updates on rising edge.
- system1000_rstn  input  1  reset, asynchronous, active-low.
- start_i  input  1  pulse: begin/restart a load at address 0.
- cmd_valid_i  input  1  command valid.
- cmd_ready_o  output  1  command accepted when high together with cmd_valid_i.
- cmd_kind_i  input  3  0 ALU, 1 Jump, 2 Load, 3 Store, 4 Push, 5 Pop, 6 EndProg, 7 illegal.
- cmd_sel_i  input  1  Load/Store variant: 1 immediate, 0 memory/register.
- cmd_op_i  input  5  ALU opcode.
- cmd_ra_i  input  5  ALU r0 / Load rid / Store reg / Push-Pop reg.
- cmd_rb_i  input  5  ALU r1.
- cmd_rc_i  input  5  ALU r2.
- cmd_imm_i  input  16  signed immediate.
- cmd_addr_i  input  7  data memory address.
- cmd_jtype_i  input  3  jump type.
- cmd_jaddr_i  input  8  signed jump offset.
- imem_we_o  output  1  instruction RAM write strobe.
- imem_addr_o  output  ADDR_W  write address.
- imem_wdata_o  output  27  encoded instruction.
- done_o  output  1  EndProg written; sticky until start.
- err_o  output  1  overflow (or illegal kind, see option); sticky until start.
- count_o  output  ADDR_W+1  words written in current load.

Behaviour:
- Reset (async, rstn low):
  - State IDLE.
  - imem_we_o=0, imem_addr_o=0, imem_wdata_o=0, done_o=0, err_o=0, count_o=0, write pointer=0.
- FSM states IDLE, LOAD, DONE, ERR:
  - start_i in any state: next cycle state=LOAD, pointer=0, count=0, done/err cleared.
  - LOAD, accepted EndProg -> DONE.
  - LOAD, accepted non-EndProg with pointer==DEPTH-1 -> ERR.
  - Otherwise stay in LOAD.
- cmd_ready_o = (state==LOAD) && !start_i; combinational. start_i takes priority: a command presented in the same cycle is not accepted.
- Latency: on an accepted command, the next cycle has:
  - imem_we_o=1 for exactly one cycle;
  - imem_addr_o=pointer, imem_wdata_o=encoded word;
  - pointer and count_o incremented.
  - imem_addr_o/imem_wdata_o hold their last value while imem_we_o=0.
- Back-to-back acceptance every cycle supported (throughput 1 word/clock).
- Encoding: bits [26:24]=kind; all bits not listed are 0.
  - ALU: [23:19]=op, [18:14]=ra, [13:9]=rb, [8:4]=rc.
  - Jump: [23:21]=jtype, [20:13]=jaddr.
  - Load: [23]=sel, [6:2]=ra.
    - sel=1: [22:7]=imm.
    - sel=0: [22:16]=addr.
  - Store: [23]=sel, [6:0]=addr.
    - sel=1: [22:7]=imm.
    - sel=0: [22:18]=ra.
  - Push/Pop: [23:19]=ra.
  - EndProg: kind only.
- Boundaries:
  - DONE/ERR assert in the same cycle as the final write strobe.
  - The DEPTH-th word is written before entering ERR.
  - An EndProg landing at DEPTH-1 -> DONE, not ERR.
  - No writes in IDLE, DONE or ERR.
  - Reset mid-load aborts immediately; a pending strobe is dropped.

Optional Feature:
- ENC_ILLEGAL_CHECK_EN.
- Defined: a kind=7 command is accepted but not written (no strobe, pointer unchanged); err_o=1 and state=ERR next cycle.
- Undefined: kind=7 is encoded with the ALU field layout and [26:24]=7; the decoder treats it as ALU.

Test Plan:
- Reset, start, ALU op=5 ra=1 rb=2 rc=3 -> next cycle we=1, addr=0, wdata=0x0284430, count=1.
- Load sel=1 imm=0x1234 ra=7, then Jump jtype=3 jaddr=-2, back-to-back -> wdata 0x2891A1C @0, 0x17FC000 @1, strobes on consecutive cycles.
- Store sel=0 ra=9 addr=0x45, Push ra=4, EndProg -> 0x3240045, 0x4200000, 0x6000000 at addresses 0..2; done_o=1 with the third strobe; cmd_ready_o=0 afterwards.
- DEPTH=4, five Push commands -> four writes at 0..3, err_o=1 after the fourth, fifth never accepted.
- start_i and cmd_valid_i asserted together mid-load -> command not accepted, pointer=0 next cycle; rstn pulsed low during a strobe -> all outputs 0 at once.
- kind=7 -> with ENC_ILLEGAL_CHECK_EN: no write, err_o=1; without: write of 0x7xxxxxx with ALU fields.

Source files
------------

// File: rtl/instr_encoder_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : instr_encoder_loader_if
// Description : Symbolic instruction command bus with a valid/ready handshake,
//               carried from the host/boot command source to the encoder/loader.
//               master = command source, slave = instr_encoder_loader.
// Signals     : cmd_valid/cmd_ready handshake, cmd_kind (3), cmd_sel (1),
//               cmd_op/ra/rb/rc (5 each), cmd_imm (16), cmd_addr (7),
//               cmd_jtype (3), cmd_jaddr (8)
// Revision    : 1.0 - initial release
// ============================================================================
interface instr_encoder_loader_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_kind;
  logic        cmd_sel;
  logic [4:0]  cmd_op;
  logic [4:0]  cmd_ra;
  logic [4:0]  cmd_rb;
  logic [4:0]  cmd_rc;
  logic [15:0] cmd_imm;
  logic [6:0]  cmd_addr;
  logic [2:0]  cmd_jtype;
  logic [7:0]  cmd_jaddr;

  modport master (
    output cmd_valid, cmd_kind, cmd_sel, cmd_op, cmd_ra, cmd_rb, cmd_rc,
           cmd_imm, cmd_addr, cmd_jtype, cmd_jaddr,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_kind, cmd_sel, cmd_op, cmd_ra, cmd_rb, cmd_rc,
           cmd_imm, cmd_addr, cmd_jtype, cmd_jaddr,
    output cmd_ready
  );
endinterface
`default_nettype wire

// File: rtl/instr_encoder_loader.sv
`default_nettype none
// ============================================================================
// Module      : instr_encoder_loader
// Description : Packs symbolic instruction commands into 27-bit instruction
//               words and writes them sequentially into instruction RAM from
//               address 0 until EndProg is written or the memory is full.
// Ports       : system1000       - clock (rising edge)
//               system1000_rstn  - asynchronous active-low reset
//               start_i          - begin/restart a load at address 0
//               cmd              - command bus (slave modport)
//               imem_we_o        - one-cycle write strobe per accepted word
//               imem_addr_o      - write address (held while strobe low)
//               imem_wdata_o     - encoded word (held while strobe low)
//               done_o / err_o   - sticky status, cleared by start_i
//               count_o          - words written in the current load
// Options     : ENC_ILLEGAL_CHECK_EN - when defined, kind 7 is accepted but
//               not written and forces the error state; otherwise it is
//               encoded with the ALU field layout.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_encoder_loader #(
  parameter int ADDR_W = 7,
  parameter int DEPTH  = 128
) (
  input  wire logic              system1000,
  input  wire logic              system1000_rstn,
  input  wire logic              start_i,
  instr_encoder_loader_if.slave  cmd,
  output logic                   imem_we_o,
  output logic [ADDR_W-1:0]      imem_addr_o,
  output logic [26:0]            imem_wdata_o,
  output logic                   done_o,
  output logic                   err_o,
  output logic [ADDR_W:0]        count_o
);

  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);
  localparam logic [2:0]        K_JUMP   = 3'd1;
  localparam logic [2:0]        K_LOAD   = 3'd2;
  localparam logic [2:0]        K_STORE  = 3'd3;
  localparam logic [2:0]        K_PUSH   = 3'd4;
  localparam logic [2:0]        K_POP    = 3'd5;
  localparam logic [2:0]        K_END    = 3'd6;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2,
    S_ERR  = 2'd3
  } state_t;

  state_t              state_q;
  logic [ADDR_W-1:0]   ptr_q;
  logic [ADDR_W:0]     count_q;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [26:0]         wdata_q;
  logic                done_q;
  logic                err_q;

  logic                accept_d;
  logic                illegal_d;
  logic [26:0]         enc_d;

  // start_i wins over a command presented in the same cycle.
  assign cmd.cmd_ready = (state_q == S_LOAD) && !start_i;
  assign accept_d      = cmd.cmd_valid && cmd.cmd_ready;

`ifdef ENC_ILLEGAL_CHECK_EN
  assign illegal_d = (cmd.cmd_kind == 3'd7);
`else
  assign illegal_d = 1'b0;
`endif

  // Field packing; unlisted bits stay zero. Kind 0 and 7 share the ALU layout.
  always_comb begin
    enc_d        = '0;
    enc_d[26:24] = cmd.cmd_kind;
    case (cmd.cmd_kind)
      K_JUMP: begin
        enc_d[23:21] = cmd.cmd_jtype;
        enc_d[20:13] = cmd.cmd_jaddr;
      end
      K_LOAD: begin
        enc_d[23]  = cmd.cmd_sel;
        enc_d[6:2] = cmd.cmd_ra;
        if (cmd.cmd_sel) enc_d[22:7]  = cmd.cmd_imm;
        else             enc_d[22:16] = cmd.cmd_addr;
      end
      K_STORE: begin
        enc_d[23]  = cmd.cmd_sel;
        enc_d[6:0] = cmd.cmd_addr;
        if (cmd.cmd_sel) enc_d[22:7]  = cmd.cmd_imm;
        else             enc_d[22:18] = cmd.cmd_ra;
      end
      K_PUSH, K_POP: begin
        enc_d[23:19] = cmd.cmd_ra;
      end
      K_END: begin
      end
      default: begin
        enc_d[23:19] = cmd.cmd_op;
        enc_d[18:14] = cmd.cmd_ra;
        enc_d[13:9]  = cmd.cmd_rb;
        enc_d[8:4]   = cmd.cmd_rc;
      end
    endcase
  end

  always_ff @(posedge system1000 or negedge system1000_rstn) begin
    if (!system1000_rstn) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      count_q <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      we_q <= 1'b0;
      if (start_i) begin
        state_q <= S_LOAD;
        ptr_q   <= '0;
        count_q <= '0;
        done_q  <= 1'b0;
        err_q   <= 1'b0;
      end else if (accept_d && illegal_d) begin
        err_q   <= 1'b1;
        state_q <= S_ERR;
      end else if (accept_d) begin
        we_q    <= 1'b1;
        addr_q  <= ptr_q;
        wdata_q <= enc_d;
        ptr_q   <= ptr_q + 1'b1;
        count_q <= count_q + 1'b1;
        // EndProg in the last slot still finishes cleanly.
        if (cmd.cmd_kind == K_END) begin
          done_q  <= 1'b1;
          state_q <= S_DONE;
        end else if (ptr_q == LAST_PTR) begin
          err_q   <= 1'b1;
          state_q <= S_ERR;
        end
      end
    end
  end

  assign imem_we_o    = we_q;
  assign imem_addr_o  = addr_q;
  assign imem_wdata_o = wdata_q;
  assign done_o       = done_q;
  assign err_o        = err_q;
  assign count_o      = count_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_encoder_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_encoder_loader
// Description : Scoreboard bench for instr_encoder_loader. A driver issues
//               directed and random commands, predicts acceptance and the
//               resulting word from a reference model and queues it; a monitor
//               compares every write strobe and the status outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_encoder_loader;
  localparam int ADDR_W = 3;
  localparam int DEPTH  = 6;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic              start = 1'b0;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [26:0]       wdata;
  logic              done;
  logic              err;
  logic [ADDR_W:0]   count;

  instr_encoder_loader_if cmd_if();

  instr_encoder_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_dut (
    .system1000      (clk),
    .system1000_rstn (rstn),
    .start_i         (start),
    .cmd             (cmd_if.slave),
    .imem_we_o       (we),
    .imem_addr_o     (waddr),
    .imem_wdata_o    (wdata),
    .done_o          (done),
    .err_o           (err),
    .count_o         (count)
  );

  always #5 clk = ~clk;

  typedef struct { int unsigned addr; int unsigned data; } exp_t;
  exp_t exp_q[$];

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  bit          m_loading = 0;
  bit          m_done = 0;
  bit          m_err = 0;
  int unsigned m_ptr = 0;
  int unsigned m_count = 0;
  int unsigned last_addr = 0;
  int unsigned last_data = 0;

  task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Word layout computed from field positions with plain arithmetic.
  function automatic int unsigned encode(input int unsigned k, input int unsigned s,
      input int unsigned op, input int unsigned ra, input int unsigned rb,
      input int unsigned rc, input int unsigned imm, input int unsigned ad,
      input int unsigned jt, input int unsigned ja);
    int unsigned w;
    w = k * (2**24);
    case (k)
      1: w += jt * (2**21) + ja * (2**13);
      2: w += s ? (2**23) + imm * (2**7) + ra * 4 : ad * (2**16) + ra * 4;
      3: w += s ? (2**23) + imm * (2**7) + ad     : ra * (2**18) + ad;
      4, 5: w += ra * (2**19);
      6: ;
      default: w += op * (2**19) + ra * (2**14) + rb * (2**9) + rc * (2**4);
    endcase
    return w;
  endfunction

  // One clock of stimulus; entered and left at posedge+1.
  task automatic drive(input bit st, input bit v, input int unsigned k,
      input int unsigned s = 0, input int unsigned op = 0, input int unsigned ra = 0,
      input int unsigned rb = 0, input int unsigned rc = 0, input int unsigned imm = 0,
      input int unsigned ad = 0, input int unsigned jt = 0, input int unsigned ja = 0);
    bit   exp_rdy;
    bit   acc;
    exp_t e;
    start            = st;
    cmd_if.cmd_valid = v;
    cmd_if.cmd_kind  = k[2:0];
    cmd_if.cmd_sel   = s[0];
    cmd_if.cmd_op    = op[4:0];
    cmd_if.cmd_ra    = ra[4:0];
    cmd_if.cmd_rb    = rb[4:0];
    cmd_if.cmd_rc    = rc[4:0];
    cmd_if.cmd_imm   = imm[15:0];
    cmd_if.cmd_addr  = ad[6:0];
    cmd_if.cmd_jtype = jt[2:0];
    cmd_if.cmd_jaddr = ja[7:0];
    @(negedge clk);
    exp_rdy = m_loading && !st;
    chk("cmd_ready", cmd_if.cmd_ready, exp_rdy);
    acc = exp_rdy && v;
    @(posedge clk);
    if (st) begin
      m_loading = 1; m_done = 0; m_err = 0; m_ptr = 0; m_count = 0;
    end else if (acc) begin
`ifdef ENC_ILLEGAL_CHECK_EN
      if (k == 7) begin
        m_err = 1; m_loading = 0;
      end else begin
`else
      begin
`endif
        e.addr = m_ptr;
        e.data = encode(k, s, op, ra, rb, rc, imm, ad, jt, ja);
        exp_q.push_back(e);
        m_ptr++; m_count++;
        if (k == 6) begin m_done = 1; m_loading = 0; end
        else if (m_ptr == DEPTH) begin m_err = 1; m_loading = 0; end
      end
    end
    #1;
    start = 1'b0;
    cmd_if.cmd_valid = 1'b0;
  endtask

  // Monitor: every strobe must match the oldest queued word.
  always @(negedge clk) begin
    exp_t e;
    if (we) begin
      if (exp_q.size() == 0) begin
        chk("stray_write", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("imem_addr", waddr, e.addr);
        chk("imem_wdata", wdata, e.data);
        last_addr = e.addr;
        last_data = e.data;
      end
    end else begin
      chk("addr_hold", waddr, last_addr);
      chk("wdata_hold", wdata, last_data);
    end
    chk("done_o", done, m_done);
    chk("err_o", err, m_err);
    chk("count_o", count, m_count);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    cmd_if.cmd_valid = 0; cmd_if.cmd_kind = 0; cmd_if.cmd_sel = 0;
    cmd_if.cmd_op = 0; cmd_if.cmd_ra = 0; cmd_if.cmd_rb = 0; cmd_if.cmd_rc = 0;
    cmd_if.cmd_imm = 0; cmd_if.cmd_addr = 0; cmd_if.cmd_jtype = 0; cmd_if.cmd_jaddr = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #2 rstn = 1'b1;
    @(posedge clk); #1;

    // Idle after reset: command must be ignored.
    drive(0, 1, 0, 0, 5, 1, 2, 3);
    // ALU at address 0
    drive(1, 0, 0);
    drive(0, 1, 0, 0, 5, 1, 2, 3);
    drive(0, 0, 0);
    // Load imm then Jump back-to-back
    drive(1, 0, 0);
    drive(0, 1, 2, 1, 0, 7, 0, 0, 16'h1234);
    drive(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 3, 8'hFE);
    drive(0, 0, 0);
    // Store mem, Push, EndProg, then ready must stay low
    drive(1, 0, 0);
    drive(0, 1, 3, 0, 0, 9, 0, 0, 0, 7'h45);
    drive(0, 1, 4, 0, 0, 4);
    drive(0, 1, 6);
    drive(0, 1, 4, 0, 0, 4);
    drive(0, 0, 0);
    // Overflow: DEPTH+1 pushes, last one refused
    drive(1, 0, 0);
    for (int i = 0; i <= DEPTH; i++) drive(0, 1, 4, 0, 0, i);
    drive(0, 0, 0);
    // EndProg landing in the last slot finishes as DONE
    drive(1, 0, 0);
    for (int i = 0; i < DEPTH - 1; i++) drive(0, 1, 5, 0, 0, 30 - i);
    drive(0, 1, 6);
    drive(0, 0, 0);
    // start together with a valid command mid-load
    drive(1, 0, 0);
    drive(0, 1, 0, 0, 1, 2, 3, 4);
    drive(0, 1, 0, 0, 6, 7, 8, 9);
    drive(1, 1, 4, 0, 0, 17);
    drive(0, 1, 2, 0, 0, 3, 0, 0, 0, 7'h7F);
    drive(0, 0, 0);
    // Reset asserted while a strobe is high
    drive(0, 1, 3, 1, 0, 0, 0, 0, 16'hBEEF, 7'h12);
    #1 rstn = 1'b0;
    exp_q.delete();
    m_loading = 0; m_done = 0; m_err = 0; m_ptr = 0; m_count = 0;
    last_addr = 0; last_data = 0;
    #1;
    chk("rst_we", we, 0);
    chk("rst_addr", waddr, 0);
    chk("rst_wdata", wdata, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_count", count, 0);
    chk("rst_ready", cmd_if.cmd_ready, 0);
    @(negedge clk);
    #2 rstn = 1'b1;
    @(posedge clk); #1;
    // Illegal kind 7
    drive(1, 0, 0);
    drive(0, 1, 4, 0, 0, 11);
    drive(0, 1, 7, 0, 21, 22, 23, 24);
    drive(0, 1, 4, 0, 0, 12);
    drive(0, 0, 0);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      bit          st;
      int unsigned k;
      st = ($urandom % 30 == 0) || (!m_loading && ($urandom % 4 == 0));
      k  = $urandom % 8;
      if (k == 6 && ($urandom % 3 != 0)) k = $urandom % 6;
      drive(st, ($urandom % 4) != 0, k, $urandom % 2, $urandom % 32, $urandom % 32,
            $urandom % 32, $urandom % 32, $urandom % 65536, $urandom % 128,
            $urandom % 8, $urandom % 256);
    end
    drive(0, 0, 0);
    drive(0, 0, 0);
    chk("queue_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
